// File: rtl/mem_stage_dmem_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_stage_dmem_ctrl_if
//   Data-memory request/response bus between the MEM-stage controller
//   (master) and the data cache (slave).
//
//   Handshake: the master raises exactly one of dmem_read_o/dmem_write_o
//   together with dmem_addr_o/dmem_mbe_o/dmem_wdata_o and holds all of them
//   stable every cycle until it samples dmem_resp_i high on a clock edge. At
//   that edge the strobe drops. dmem_resp_i is a one-cycle pulse, and
//   dmem_rdata_i is meaningful only while dmem_resp_i is high.
//
//   Signals:
//     dmem_read_o   master->slave  read request strobe
//     dmem_write_o  master->slave  write request strobe
//     dmem_addr_o   master->slave  word-aligned byte address
//     dmem_mbe_o    master->slave  byte enables
//     dmem_wdata_o  master->slave  lane-shifted store data
//     dmem_rdata_i  slave->master  read data
//     dmem_resp_i   slave->master  completion pulse
// -----------------------------------------------------------------------------
interface mem_stage_dmem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              dmem_read_o;
    logic              dmem_write_o;
    logic [ADDR_W-1:0] dmem_addr_o;
    logic [3:0]        dmem_mbe_o;
    logic [31:0]       dmem_wdata_o;
    logic [31:0]       dmem_rdata_i;
    logic              dmem_resp_i;

    modport master (
        output dmem_read_o, dmem_write_o, dmem_addr_o, dmem_mbe_o, dmem_wdata_o,
        input  dmem_rdata_i, dmem_resp_i
    );

    modport slave (
        input  dmem_read_o, dmem_write_o, dmem_addr_o, dmem_mbe_o, dmem_wdata_o,
        output dmem_rdata_i, dmem_resp_i
    );
endinterface

// File: rtl/mem_stage_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_dmem_ctrl
//   MEM-stage data-memory controller. Takes the registered EX/MEM contents,
//   issues one load or store per instruction to the data cache, stalls the
//   pipeline until the response arrives, and returns aligned and
//   sign/zero-extended load data toward MEM/WB.
//
//   Parameters:
//     ADDR_W        address width
//     RESP_TIMEOUT  BUSY cycles to wait for dmem_resp_i before aborting
//                   (0 = wait forever)
//
//   Optional build macro:
//     MEM_MISALIGN_TRAP_EN  when defined, misaligned H/HU/W accesses raise
//                           misalign_o and are not issued; when undefined
//                           misalign_o is 0 and low offset bits are ignored.
//
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     ex_valid_i, mem_read_i,
//     mem_write_i, funct3_i,
//     alu_out_i, rs2_out_i          EX/MEM register contents
//     dmem                          data-cache bus (master side)
//     stall_o                       hold PC/IF/ID/EX/EX_MEM registers
//     load_data_o, load_valid_o     extended load result and its update pulse
//     misalign_o                    misaligned access flag
//     timeout_o                     one-cycle pulse on response timeout
//     dbg_state_o                   current FSM state (IDLE=0, BUSY=1, DONE=2)
// -----------------------------------------------------------------------------
module mem_stage_dmem_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int RESP_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] alu_out_i,
    input  logic [31:0]       rs2_out_i,
    mem_stage_dmem_ctrl_if.master dmem,
    output logic              stall_o,
    output logic [31:0]       load_data_o,
    output logic              load_valid_o,
    output logic              misalign_o,
    output logic              timeout_o,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t      state, state_next;
    logic        acc, accept, tmo_hit;
    logic        is_byte, is_half;
    logic [1:0]  off;
    logic [3:0]  req_mbe;
    logic [31:0] req_wdata;

    // Captured access attributes, used while BUSY/DONE.
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        is_load_q;
    logic        timed_out_q;
    logic [31:0] tmo_cnt;

    logic [7:0]  ext_byte;
    logic [15:0] ext_half;
    logic [31:0] load_ext;

    // A write wins when both read and write are set.
    assign acc     = ex_valid_i & (mem_read_i | mem_write_i);
    assign off     = alu_out_i[1:0];
    // funct3[1:0]: 00 byte, 01 half, anything else is a word access.
    assign is_byte = (funct3_i[1:0] == 2'b00);
    assign is_half = (funct3_i[1:0] == 2'b01);

`ifdef MEM_MISALIGN_TRAP_EN
    logic mis_acc;
    assign mis_acc    = (is_half & off[0]) | (~is_byte & ~is_half & (off != 2'b00));
    assign misalign_o = (state == IDLE) & acc & mis_acc;
    assign accept     = (state == IDLE) & acc & ~mis_acc;
`else
    assign misalign_o = 1'b0;
    assign accept     = (state == IDLE) & acc;
`endif

    // Lane placement: half accesses use off[1] only, word accesses ignore off.
    always_comb begin
        req_mbe   = 4'b1111;
        req_wdata = rs2_out_i;
        if (is_byte) begin
            req_mbe   = 4'b0001 << off;
            req_wdata = rs2_out_i << {off, 3'b000};
        end else if (is_half) begin
            req_mbe   = off[1] ? 4'b1100 : 4'b0011;
            req_wdata = off[1] ? {rs2_out_i[15:0], 16'h0000} : rs2_out_i;
        end
    end

    // Load extraction from the response word using the captured offset/size.
    always_comb begin
        case (off_q)
            2'd0:    ext_byte = dmem.dmem_rdata_i[7:0];
            2'd1:    ext_byte = dmem.dmem_rdata_i[15:8];
            2'd2:    ext_byte = dmem.dmem_rdata_i[23:16];
            default: ext_byte = dmem.dmem_rdata_i[31:24];
        endcase
        ext_half = off_q[1] ? dmem.dmem_rdata_i[31:16] : dmem.dmem_rdata_i[15:0];
        case (f3_q[1:0])
            2'b00:   load_ext = {{24{~f3_q[2] & ext_byte[7]}}, ext_byte};
            2'b01:   load_ext = {{16{~f3_q[2] & ext_half[15]}}, ext_half};
            default: load_ext = dmem.dmem_rdata_i;
        endcase
    end

    // Timeout fires after RESP_TIMEOUT BUSY cycles without a response;
    // a response in the same cycle takes priority.
    assign tmo_hit = (RESP_TIMEOUT > 0) && (tmo_cnt == 32'(RESP_TIMEOUT - 1))
                     && !dmem.dmem_resp_i;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall_o    = 1'b0;
        case (state)
            IDLE: begin
                stall_o = accept;
                if (accept) state_next = BUSY;
            end
            BUSY: begin
                stall_o = 1'b1;
                if (dmem.dmem_resp_i || tmo_hit) state_next = DONE;
            end
            // EX/MEM advances here; the next instruction is seen in IDLE.
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmem.dmem_read_o  <= 1'b0;
            dmem.dmem_write_o <= 1'b0;
            dmem.dmem_addr_o  <= '0;
            dmem.dmem_mbe_o   <= 4'b0000;
            dmem.dmem_wdata_o <= 32'h0;
            load_data_o       <= 32'h0;
            off_q             <= 2'b00;
            f3_q              <= 3'b000;
            is_load_q         <= 1'b0;
            timed_out_q       <= 1'b0;
            tmo_cnt           <= 32'h0;
        end else if (accept) begin
            dmem.dmem_read_o  <= ~mem_write_i;
            dmem.dmem_write_o <= mem_write_i;
            dmem.dmem_addr_o  <= {alu_out_i[ADDR_W-1:2], 2'b00};
            dmem.dmem_mbe_o   <= req_mbe;
            dmem.dmem_wdata_o <= req_wdata;
            off_q             <= off;
            f3_q              <= funct3_i;
            is_load_q         <= ~mem_write_i;
            timed_out_q       <= 1'b0;
            tmo_cnt           <= 32'h0;
        end else if (state == BUSY) begin
            if (dmem.dmem_resp_i) begin
                dmem.dmem_read_o  <= 1'b0;
                dmem.dmem_write_o <= 1'b0;
                if (is_load_q) load_data_o <= load_ext;
            end else if (tmo_hit) begin
                dmem.dmem_read_o  <= 1'b0;
                dmem.dmem_write_o <= 1'b0;
                timed_out_q       <= 1'b1;
            end else begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end
        end
    end

    assign load_valid_o = (state == DONE) & is_load_q & ~timed_out_q;
    assign timeout_o    = (state == DONE) & timed_out_q;
    assign dbg_state_o  = state;

endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_dmem_ctrl
//   Directed and randomized accesses against mem_stage_dmem_ctrl. Expected
//   bus fields and load results come from a size/offset arithmetic model.
// -----------------------------------------------------------------------------
module tb_mem_stage_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid_i = 1'b0;
    logic        mem_read_i = 1'b0;
    logic        mem_write_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] alu_out_i = 32'h0;
    logic [31:0] rs2_out_i = 32'h0;
    logic        stall_o;
    logic [31:0] load_data_o;
    logic        load_valid_o;
    logic        misalign_o;
    logic        timeout_o;
    logic [1:0]  dbg_state;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] model_load = 32'h0;
    logic [31:0] exp_q[$];

    mem_stage_dmem_ctrl_if #(.ADDR_W(32)) dmem_bus ();

    mem_stage_dmem_ctrl #(.ADDR_W(32), .RESP_TIMEOUT(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid_i   (ex_valid_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .funct3_i     (funct3_i),
        .alu_out_i    (alu_out_i),
        .rs2_out_i    (rs2_out_i),
        .dmem         (dmem_bus.master),
        .stall_o      (stall_o),
        .load_data_o  (load_data_o),
        .load_valid_o (load_valid_o),
        .misalign_o   (misalign_o),
        .timeout_o    (timeout_o),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_extract(input logic [2:0] f3, input logic [31:0] addr,
                                                  input logic [31:0] rdata);
        int nb, eo;
        logic [31:0] raw, mask, v;
        nb  = size_bytes(f3);
        eo  = ((addr % 4) / nb) * nb;
        raw = rdata >> (8 * eo);
        if (nb == 4) return raw;
        mask = (32'd1 << (8 * nb)) - 32'd1;
        v    = raw & mask;
        if (f3[2] == 1'b0 && raw[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic drive(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2);
        ex_valid_i = v; mem_read_i = rd; mem_write_i = wr;
        funct3_i = f3; alu_out_i = addr; rs2_out_i = rs2;
    endtask

    // ---------------- driver ----------------
    task automatic run_access(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] rs2,
                              input int delay, input logic [31:0] rdata);
        int nb, eo;
        logic issue, is_ld;
        logic [3:0]  e_mbe;
        logic [31:0] e_wd, got;
        nb    = size_bytes(f3);
        eo    = ((addr % 4) / nb) * nb;
        e_mbe = 4'(((1 << nb) - 1) << eo);
        e_wd  = rs2 << (8 * eo);
        issue = v & (rd | wr);
        is_ld = issue & ~wr;
`ifdef MEM_MISALIGN_TRAP_EN
        if (issue && (addr % nb) != 0) begin
            @(negedge clk); drive(v, rd, wr, f3, addr, rs2); #1;
            check("mis_flag", 32'(misalign_o), 32'd1);
            check("mis_stall", 32'(stall_o), 32'd0);
            check("mis_strobe", 32'({dmem_bus.dmem_read_o, dmem_bus.dmem_write_o}), 32'd0);
            @(negedge clk); drive(0, 0, 0, 3'b000, 32'h0, 32'h0); #1;
            check("mis_after_strobe", 32'({dmem_bus.dmem_read_o, dmem_bus.dmem_write_o}), 32'd0);
            check("mis_load_data", load_data_o, model_load);
            return;
        end
`endif
        @(negedge clk); drive(v, rd, wr, f3, addr, rs2); #1;
        check("idle_stall", 32'(stall_o), 32'(issue));
        check("idle_misalign", 32'(misalign_o), 32'd0);
        check("idle_no_strobe", 32'({dmem_bus.dmem_read_o, dmem_bus.dmem_write_o}), 32'd0);
        if (!issue) begin
            @(negedge clk); drive(0, 0, 0, 3'b000, 32'h0, 32'h0); #1;
            check("nobubble_strobe", 32'({dmem_bus.dmem_read_o, dmem_bus.dmem_write_o}), 32'd0);
            check("nobubble_stall", 32'(stall_o), 32'd0);
            return;
        end
        if (is_ld) begin
            model_load = model_extract(f3, addr, rdata);
            exp_q.push_back(model_load);
        end
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            if (k == delay - 1) begin
                dmem_bus.dmem_resp_i = 1'b1; dmem_bus.dmem_rdata_i = rdata;
            end else begin
                dmem_bus.dmem_resp_i = 1'b0; dmem_bus.dmem_rdata_i = $urandom;
            end
            #1;
            check("busy_read", 32'(dmem_bus.dmem_read_o), 32'(is_ld));
            check("busy_write", 32'(dmem_bus.dmem_write_o), 32'(wr));
            check("busy_addr", dmem_bus.dmem_addr_o, {addr[31:2], 2'b00});
            check("busy_mbe", 32'(dmem_bus.dmem_mbe_o), 32'(e_mbe));
            if (wr) check("busy_wdata", dmem_bus.dmem_wdata_o, e_wd);
            check("busy_stall", 32'(stall_o), 32'd1);
            check("busy_load_valid", 32'(load_valid_o), 32'd0);
        end
        @(negedge clk);
        dmem_bus.dmem_resp_i = 1'b0;
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
        #1;
        check("done_stall", 32'(stall_o), 32'd0);
        check("done_strobe", 32'({dmem_bus.dmem_read_o, dmem_bus.dmem_write_o}), 32'd0);
        check("done_load_valid", 32'(load_valid_o), 32'(is_ld));
        check("done_timeout", 32'(timeout_o), 32'd0);
        if (is_ld && exp_q.size() > 0) begin
            got = exp_q.pop_front();
            check("done_load_data", load_data_o, got);
        end else begin
            check("done_load_hold", load_data_o, model_load);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] f3_tab[5];
        logic       rv, rr, rw;
        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        dmem_bus.dmem_resp_i  = 1'b0;
        dmem_bus.dmem_rdata_i = 32'h0;

        // reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_read", 32'(dmem_bus.dmem_read_o), 32'd0);
        check("rst_write", 32'(dmem_bus.dmem_write_o), 32'd0);
        check("rst_addr", dmem_bus.dmem_addr_o, 32'h0);
        check("rst_mbe", 32'(dmem_bus.dmem_mbe_o), 32'd0);
        check("rst_wdata", dmem_bus.dmem_wdata_o, 32'h0);
        check("rst_load_data", load_data_o, 32'h0);
        check("rst_load_valid", 32'(load_valid_o), 32'd0);
        check("rst_misalign", 32'(misalign_o), 32'd0);
        check("rst_timeout", 32'(timeout_o), 32'd0);

        // SW, 3 BUSY cycles before response
        run_access(1, 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 3, 32'h0);
        // SB at byte lane 3
        run_access(1, 0, 1, 3'b000, 32'h203, 32'h000000A5, 1, 32'h0);
        // LB / LBU / LHU at 0x302
        run_access(1, 1, 0, 3'b000, 32'h302, 32'h0, 1, 32'h12F45678);
        check("lb_value", load_data_o, 32'hFFFFFFF4);
        run_access(1, 1, 0, 3'b100, 32'h302, 32'h0, 1, 32'h12F45678);
        check("lbu_value", load_data_o, 32'h000000F4);
        run_access(1, 1, 0, 3'b101, 32'h302, 32'h0, 1, 32'h12F45678);
        check("lhu_value", load_data_o, 32'h000012F4);
        // back-to-back LW then SW
        run_access(1, 1, 0, 3'b010, 32'h400, 32'h0, 2, 32'hCAFEF00D);
        run_access(1, 0, 1, 3'b010, 32'h404, 32'h11223344, 1, 32'h0);
        // read and write both set: treated as write
        run_access(1, 1, 1, 3'b001, 32'h612, 32'h0000BEEF, 2, 32'h0);
        // bubble carrying a read
        run_access(0, 1, 0, 3'b010, 32'h700, 32'h0, 1, 32'h0);

        // reset while BUSY, response arriving a cycle later
        @(negedge clk); drive(1, 1, 0, 3'b010, 32'h800, 32'h0); #1;
        @(negedge clk); drive(0, 0, 0, 3'b000, 32'h0, 32'h0); #1;
        check("rstbusy_read", 32'(dmem_bus.dmem_read_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dmem_bus.dmem_resp_i = 1'b1; dmem_bus.dmem_rdata_i = 32'hFFFFFFFF;
        #1;
        model_load = 32'h0;
        exp_q.delete();
        check("rstbusy_strobe", 32'({dmem_bus.dmem_read_o, dmem_bus.dmem_write_o}), 32'd0);
        check("rstbusy_stall", 32'(stall_o), 32'd0);
        check("rstbusy_load_data", load_data_o, 32'h0);
        @(negedge clk); dmem_bus.dmem_resp_i = 1'b0; #1;
        check("rstbusy_late_valid", 32'(load_valid_o), 32'd0);
        check("rstbusy_late_data", load_data_o, 32'h0);
        check("rstbusy_late_strobe", 32'({dmem_bus.dmem_read_o, dmem_bus.dmem_write_o}), 32'd0);

        // misaligned LW (trap or issue at 0x500 depending on build)
        run_access(1, 1, 0, 3'b010, 32'h502, 32'h0, 1, 32'h89ABCDEF);
        run_access(1, 1, 0, 3'b001, 32'h503, 32'h0, 2, 32'h80017F02);

        // randomized accesses
        for (int i = 0; i < 40; i++) begin
            rv = ($urandom_range(0, 7) != 0);
            rr = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            run_access(rv, rr, rw, f3_tab[$urandom_range(0, 4)], $urandom, $urandom,
                       $urandom_range(1, 4), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
